// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller.
//   state_e  : controller state encoding (IDLE/RUN/DONE)
//   NIB_W    : width of the shared adder slice
//   clog2()  : index width helper for the nibble counter
package nibble_serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NIB_W = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_rca4.sv
// 4-bit ripple-carry adder used as the single shared datapath slice.
// Ports:
//   a, b : 4-bit addends
//   ci   : carry in
//   s    : 4-bit sum
//   co   : carry out of bit 3
module ripple_carry_adder_4bit
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co
);

  logic [NIB_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < NIB_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder controller: adds WIDTH-bit operands through one shared
// 4-bit ripple-carry adder, least-significant nibble first, one nibble per
// clock, holding the inter-nibble carry in a register.
// Optional build macro: ADDER_SUB_EN (adds sub input and ovf output; sub=1
// computes a - b).
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : request, accepted only when not busy (IDLE or DONE)
//   a, b, cin    : operands and carry-in, latched on the accepted start
//   sub          : (ADDER_SUB_EN) subtract select, latched with a/b
//   busy         : high in RUN
//   done         : one-cycle pulse when sum/cout are valid
//   sum, cout    : result register and top carry-out
//   ovf          : (ADDER_SUB_EN) signed overflow, loads with cout
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int IDX_W   = clog2(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               sub_q, sub_d;
  logic               ovf_q, ovf_d;
  logic               sub_in;

  logic [IDX_W+1:0]   nib_lsb;
  logic [NIB_W-1:0]   add_a, add_b, add_s;
  logic               add_co;

`ifdef ADDER_SUB_EN
  assign sub_in = sub;
  assign ovf    = ovf_q;
`else
  assign sub_in = 1'b0;
`endif

  // Nibble offset is idx*4; the shift is exact because NIB_W is fixed at 4.
  assign nib_lsb = {idx_q, 2'b00};
  assign add_a   = a_q[nib_lsb +: NIB_W];
  // Subtraction is a + ~b + 1: invert B per nibble, the +1 rides in carry_q.
  assign add_b   = b_q[nib_lsb +: NIB_W] ^ {NIB_W{sub_q}};

  ripple_carry_adder_4bit u_rca (
    .a  (add_a),
    .b  (add_b),
    .ci (carry_q),
    .s  (add_s),
    .co (add_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    sub_d   = sub_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = b;
          sub_d   = sub_in;
          carry_d = sub_in ? 1'b1 : cin;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        sum_d[nib_lsb +: NIB_W] = add_s;
        carry_d = add_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          cout_d  = add_co;
          // Overflow when both effective operands share a sign the result lacks.
          ovf_d   = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sub_q)) &&
                    (add_s[NIB_W-1] != a_q[WIDTH-1]);
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      sub_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      sub_q   <= sub_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

  logic unused_ok;
  assign unused_ok = ^{ovf_q, sub_q};

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (WIDTH=16).
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;
`ifdef ADDER_SUB_EN
  logic             sub;
  logic             ovf;
`endif

  int n_vec;
  int n_bad;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef ADDER_SUB_EN
    .sub   (sub),
    .ovf   (ovf),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands and pulse start for one edge; returns #1 after that edge.
  task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic ci, input logic sb);
    start = 1'b1;
    a     = av;
    b     = bv;
    cin   = ci;
`ifdef ADDER_SUB_EN
    sub   = sb;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
`ifdef ADDER_SUB_EN
    sub   = 1'b0;
`endif
  endtask

  // Bounded wait for done; cyc = edges waited.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic idle_cycles(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
  endtask

  int cyc;
  int pulses;
  logic sb0;

  initial begin
    n_vec = 0;
    n_bad = 0;
    sb0   = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'h0);
    chk("rst_cout", 32'(cout), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic add
    start_op(16'h1234, 16'h4321, 1'b0, sb0);
    chk("basic_busy", 32'(busy), 32'd1);
    wait_done(cyc);
    chk("basic_lat",  32'(cyc),  32'd4);
    chk("basic_sum",  32'(sum),  32'h5555);
    chk("basic_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;
    chk("basic_done_1cyc", 32'(done), 32'd0);
    chk("basic_hold_sum",  32'(sum),  32'h5555);

    // Full ripple through all nibbles
    start_op(16'hFFFF, 16'h0001, 1'b0, sb0);
    wait_done(cyc);
    chk("rip1_sum",  32'(sum),  32'h0000);
    chk("rip1_cout", 32'(cout), 32'd1);
    @(posedge clk); #1;
    start_op(16'hFFFF, 16'h0000, 1'b1, sb0);
    wait_done(cyc);
    chk("rip2_sum",  32'(sum),  32'h0000);
    chk("rip2_cout", 32'(cout), 32'd1);
    @(posedge clk); #1;
    start_op(16'h8000, 16'h8000, 1'b1, sb0);
    wait_done(cyc);
    chk("top_sum",  32'(sum),  32'h0001);
    chk("top_cout", 32'(cout), 32'd1);
    @(posedge clk); #1;
    start_op(16'h0F0F, 16'h0101, 1'b1, sb0);
    wait_done(cyc);
    chk("mix_sum",  32'(sum),  32'h1011);
    chk("mix_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;

    // Start during RUN is ignored
    start_op(16'h0001, 16'h0001, 1'b0, sb0);
    @(posedge clk); #1;
    start = 1'b1;
    a     = 16'hAAAA;
    @(posedge clk); #1;
    start = 1'b0;
    a     = '0;
    wait_done(cyc);
    chk("rej_lat", 32'(cyc), 32'd2);
    chk("rej_sum", 32'(sum), 32'h0002);
    idle_cycles(7, pulses);
    chk("rej_no_2nd_done", 32'(pulses), 32'd0);
    chk("rej_idle_busy",   32'(busy),   32'd0);

    // Back-to-back across DONE
    start_op(16'h0001, 16'h0001, 1'b0, sb0);
    wait_done(cyc);
    chk("b2b_first_sum", 32'(sum), 32'h0002);
    start_op(16'h00F0, 16'h0010, 1'b0, sb0);
    chk("b2b_resume_busy", 32'(busy), 32'd1);
    chk("b2b_resume_done", 32'(done), 32'd0);
    wait_done(cyc);
    chk("b2b_lat",  32'(cyc),  32'd4);
    chk("b2b_sum",  32'(sum),  32'h0100);
    chk("b2b_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;

    // Reset mid-operation
    start_op(16'hFFFF, 16'hFFFF, 1'b1, sb0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_sum",  32'(sum),  32'h0000);
    chk("mrst_cout", 32'(cout), 32'd0);
    idle_cycles(7, pulses);
    chk("mrst_no_done", 32'(pulses), 32'd0);

`ifdef ADDER_SUB_EN
    start_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_done(cyc);
    chk("sub1_sum",  32'(sum),  32'hFFFE);
    chk("sub1_cout", 32'(cout), 32'd0);
    chk("sub1_ovf",  32'(ovf),  32'd0);
    @(posedge clk); #1;
    start_op(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_done(cyc);
    chk("sub2_sum",  32'(sum),  32'h7FFF);
    chk("sub2_cout", 32'(cout), 32'd1);
    chk("sub2_ovf",  32'(ovf),  32'd1);
    @(posedge clk); #1;
    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done(cyc);
    chk("addovf_sum", 32'(sum), 32'h8000);
    chk("addovf_ovf", 32'(ovf), 32'd1);
    @(posedge clk); #1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
